// File: rtl/note_scroll_sched.sv
// rtl/note_scroll_sched.sv - four-lane falling-note scroll scheduler and hit judge
//
// Reads one note row per row period from the note ROM, shifts it through a
// ROWS-deep grid, exposes the sub-row step for smooth rendering and judges
// key presses against the bottom (hit) row.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   start              one-cycle pulse, begins a song from IDLE or END
//   abort              level, returns to IDLE (grid cleared, counts kept)
//   key[3:0]           raw key levels, bit3 = leftmost lane
//   rom_addr, rom_data note ROM address / lane bits (1-cycle read latency)
//   grid[4*ROWS-1:0]   row r at bits [4r+3:4r], row ROWS-1 is the hit row
//   step[2:0]          sub-row scroll step, 0..STEPS_PER_ROW-1
//   busy               high while scrolling (RUN or DRAIN)
//   hit_pulse          one cycle per judgement that hit at least one lane
//   miss_pulse         one cycle per shift that dropped at least one note
//   hit_count          saturating hit total
//   miss_count         saturating miss total
//   done, fail         song completed / miss limit reached (levels)
module note_scroll_sched #(
   parameter int TICK_DIV      = 1000000,
   parameter int STEPS_PER_ROW = 5,
   parameter int ROWS          = 11,
   parameter int ADDR_W        = 13,
   parameter int SONG_LEN      = 4096,
   parameter int MISS_LIMIT    = 15
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [3:0]        key,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_data,
   output logic [4*ROWS-1:0] grid,
   output logic [2:0]        step,
   output logic              busy,
   output logic              hit_pulse,
   output logic              miss_pulse,
   output logic [7:0]        hit_count,
   output logic [7:0]        miss_count,
   output logic              done,
   output logic              fail
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(ROWS + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_END} state_t;

   state_t            state;
   logic [TW-1:0]     tick_cnt;
   logic [DW-1:0]     drain_cnt;
   logic [3:0]        key_q;
   logic [3:0]        key_prev;

   logic              active;
   logic              tick;
   logic              shift;
   logic [3:0]        hit_row;
   logic [3:0]        key_rise;
   logic [3:0]        hit_mask;
   logic [3:0]        miss_bits;
   logic [8:0]        hit_sum;
   logic [8:0]        miss_sum;
   logic [7:0]        hit_sat;
   logic [7:0]        miss_sat;
   logic [ADDR_W-1:0] addr_next;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   always_comb begin
      active    = (state == S_RUN) || (state == S_DRAIN);
      tick      = active && (tick_cnt == TW'(TICK_DIV - 1));
      shift     = tick && (step == 3'(STEPS_PER_ROW - 1));
      hit_row   = grid[4*ROWS-1 -: 4];
      key_rise  = key_q & ~key_prev;
      hit_mask  = active ? (key_rise & hit_row) : 4'b0000;
      // A lane judged as hit in the shift cycle is already gone, so it
      // cannot also be counted as a miss.
      miss_bits = shift ? (hit_row & ~hit_mask) : 4'b0000;
      hit_sum   = {1'b0, hit_count} + {6'b000000, popcnt4(hit_mask)};
      miss_sum  = {1'b0, miss_count} + {6'b000000, popcnt4(miss_bits)};
      hit_sat   = hit_sum[8] ? 8'hFF : hit_sum[7:0];
      miss_sat  = miss_sum[8] ? 8'hFF : miss_sum[7:0];
      addr_next = (rom_addr == ADDR_W'(SONG_LEN)) ? rom_addr : rom_addr + ADDR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= S_IDLE;
         tick_cnt   <= '0;
         drain_cnt  <= '0;
         key_q      <= 4'b0000;
         key_prev   <= 4'b0000;
         rom_addr   <= '0;
         grid       <= '0;
         step       <= 3'd0;
         busy       <= 1'b0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         hit_count  <= 8'd0;
         miss_count <= 8'd0;
         done       <= 1'b0;
         fail       <= 1'b0;
      end else begin
         key_q      <= key;
         key_prev   <= key_q;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         if (abort) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            grid     <= '0;
            step     <= 3'd0;
            tick_cnt <= '0;
         end else begin
            case (state)
               S_IDLE, S_END: begin
                  if (start) begin
                     state      <= S_RUN;
                     busy       <= 1'b1;
                     grid       <= '0;
                     step       <= 3'd0;
                     tick_cnt   <= '0;
                     drain_cnt  <= '0;
                     rom_addr   <= '0;
                     hit_count  <= 8'd0;
                     miss_count <= 8'd0;
                     done       <= 1'b0;
                     fail       <= 1'b0;
                  end
               end
               default: begin
                  tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
                  hit_count <= hit_sat;
                  hit_pulse <= |hit_mask;
                  if (shift) begin
                     step       <= 3'd0;
                     // The outgoing hit row is dropped; its misses were
                     // taken from miss_bits above.
                     grid       <= {grid[4*ROWS-5:0], (state == S_RUN) ? rom_data : 4'b0000};
                     rom_addr   <= addr_next;
                     miss_count <= miss_sat;
                     miss_pulse <= |miss_bits;
                     if (miss_sat >= 8'(MISS_LIMIT)) begin
                        state <= S_END;
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                     end else if (state == S_RUN && addr_next == ADDR_W'(SONG_LEN)) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                     end else if (state == S_DRAIN) begin
                        if (drain_cnt == DW'(ROWS - 1)) begin
                           state <= S_END;
                           busy  <= 1'b0;
                           done  <= 1'b1;
                        end else begin
                           drain_cnt <= drain_cnt + DW'(1);
                        end
                     end
                  end else begin
                     if (tick) begin
                        step <= step + 3'd1;
                     end
                     grid[4*ROWS-1 -: 4] <= hit_row & ~hit_mask;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_note_scroll_sched.sv
// tb/tb_note_scroll_sched.sv - bench for note_scroll_sched
module tb_note_scroll_sched;

   localparam int TICK_DIV   = 4;
   localparam int STEPS      = 5;
   localparam int ROWS       = 11;
   localparam int ADDR_W     = 13;
   localparam int SONG_LEN   = 16;
   localparam int MISS_LIMIT = 3;
   localparam int ROW_T      = TICK_DIV * STEPS;

   logic              clk      = 1'b0;
   logic              resetn   = 1'b0;
   logic              start    = 1'b0;
   logic              abort    = 1'b0;
   logic [3:0]        key      = 4'b0000;
   logic [3:0]        rom_data = 4'b0000;
   logic [ADDR_W-1:0] rom_addr;
   logic [4*ROWS-1:0] grid;
   logic [2:0]        step;
   logic              busy;
   logic              hit_pulse;
   logic              miss_pulse;
   logic [7:0]        hit_count;
   logic [7:0]        miss_count;
   logic              done;
   logic              fail;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0       = 0;
   logic chk_en = 1'b1;

   logic [3:0] rom [0:SONG_LEN-1];

   note_scroll_sched #(
      .TICK_DIV(TICK_DIV), .STEPS_PER_ROW(STEPS), .ROWS(ROWS),
      .ADDR_W(ADDR_W), .SONG_LEN(SONG_LEN), .MISS_LIMIT(MISS_LIMIT)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .abort(abort), .key(key),
      .rom_addr(rom_addr), .rom_data(rom_data), .grid(grid), .step(step),
      .busy(busy), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
      .hit_count(hit_count), .miss_count(miss_count), .done(done), .fail(fail)
   );

   always #5 clk = ~clk;

   // ROM with one cycle of read latency
   always @(posedge clk) begin
      rom_data <= (rom_addr < 13'd16) ? rom[rom_addr[3:0]] : 4'b0000;
   end

   // ---------------- reference model ----------------
   // st: 0 idle, 1 run, 2 drain, 3 end; el = cycles since start accepted.
   int         m_st = 0, m_el = 0, m_addr = 0, m_hc = 0, m_mc = 0, m_dsh = 0;
   logic [3:0] m_grid [0:ROWS-1];
   logic       m_hp = 0, m_mp = 0, m_done = 0, m_fail = 0;
   logic [3:0] ks1 = 0, ks2 = 0;

   always @(posedge clk) begin
      logic [3:0] rise, hits, outg;
      cyc++;
      if (!resetn) begin
         m_st = 0; m_el = 0; m_addr = 0; m_hc = 0; m_mc = 0; m_dsh = 0;
         m_hp = 0; m_mp = 0; m_done = 0; m_fail = 0; ks1 = 0; ks2 = 0;
         for (int r = 0; r < ROWS; r++) m_grid[r] = 4'b0000;
      end else begin
         rise = ks1 & ~ks2;
         ks2  = ks1;
         ks1  = key;
         m_hp = 0;
         m_mp = 0;
         if (abort) begin
            m_st = 0;
            for (int r = 0; r < ROWS; r++) m_grid[r] = 4'b0000;
         end else if (m_st == 0 || m_st == 3) begin
            if (start) begin
               m_st = 1; m_el = 0; t0 = cyc; m_addr = 0; m_hc = 0; m_mc = 0;
               m_done = 0; m_fail = 0;
               for (int r = 0; r < ROWS; r++) m_grid[r] = 4'b0000;
            end
         end else begin
            m_el++;
            hits = rise & m_grid[ROWS-1];
            m_grid[ROWS-1] = m_grid[ROWS-1] & ~hits;
            m_hc = m_hc + $countones(hits);
            if (m_hc > 255) m_hc = 255;
            m_hp = (hits != 0);
            if (m_el % ROW_T == 0) begin
               outg = m_grid[ROWS-1];
               m_mc = m_mc + $countones(outg);
               if (m_mc > 255) m_mc = 255;
               m_mp = (outg != 0);
               for (int r = ROWS-1; r > 0; r--) m_grid[r] = m_grid[r-1];
               m_grid[0] = (m_st == 1) ? rom[m_addr] : 4'b0000;
               if (m_addr < SONG_LEN) m_addr++;
               if (m_mc >= MISS_LIMIT) begin
                  m_st = 3; m_fail = 1;
               end else if (m_st == 1 && m_addr == SONG_LEN) begin
                  m_st = 2; m_dsh = 0;
               end else if (m_st == 2) begin
                  m_dsh++;
                  if (m_dsh == ROWS) begin
                     m_st = 3; m_done = 1;
                  end
               end
            end
         end
      end
   end

   function automatic logic [4*ROWS-1:0] model_grid();
      logic [4*ROWS-1:0] v;
      for (int r = 0; r < ROWS; r++) v[4*r +: 4] = m_grid[r];
      return v;
   endfunction

   function automatic int exp_step();
      return (m_st == 1 || m_st == 2) ? (m_el / TICK_DIV) % STEPS : 0;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // compare process: every cycle, just after the active edge
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("grid",       64'(grid),       64'(model_grid()));
         check("step",       64'(step),       64'(exp_step()));
         check("busy",       64'(busy),       64'(m_st == 1 || m_st == 2));
         check("rom_addr",   64'(rom_addr),   64'(m_addr));
         check("hit_pulse",  64'(hit_pulse),  64'(m_hp));
         check("miss_pulse", 64'(miss_pulse), 64'(m_mp));
         check("hit_count",  64'(hit_count),  64'(m_hc));
         check("miss_count", 64'(miss_count), 64'(m_mc));
         check("done",       64'(done),       64'(m_done));
         check("fail",       64'(fail),       64'(m_fail));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_rel(input int n);
      while (cyc - t0 < n) @(negedge clk);
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic go_idle();
      key = 4'b0000;
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic load_song(input logic [3:0] r0, input logic [3:0] r1);
      for (int i = 0; i < SONG_LEN; i++) rom[i] = 4'b0000;
      rom[0] = r0;
      rom[1] = r1;
   endtask

   initial begin
      for (int i = 0; i < SONG_LEN; i++) rom[i] = 4'b0000;
      repeat (3) @(negedge clk);
      check("reset_grid", 64'(grid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_addr", 64'(rom_addr), 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // single note, hit at the judgement two cycles after the key edge
      load_song(4'b1000, 4'b0000);
      do_start();
      wait_rel(19);  check("s1_step4", 64'(step), 64'd4);
      wait_rel(20);  check("s1_row0", 64'(grid[3:0]), 64'b1000);
                     check("s1_step0", 64'(step), 64'd0);
      wait_rel(220); check("s1_row10", 64'(grid[43:40]), 64'b1000);
      wait_rel(230); key = 4'b1000;
      wait_rel(231); check("s1_no_early_hit", 64'(hit_pulse), 64'd0);
      wait_rel(232); check("s1_hit_pulse", 64'(hit_pulse), 64'd1);
                     check("s1_cleared", 64'(grid[43:40]), 64'd0);
                     check("s1_hit_count", 64'(hit_count), 64'd1);
      wait_rel(240); check("s1_no_miss", 64'(miss_count), 64'd0);
      go_idle();

      // unplayed note is missed, song drains to done
      load_song(4'b1000, 4'b0000);
      do_start();
      wait_rel(240); check("s2_miss_pulse", 64'(miss_pulse), 64'd1);
                     check("s2_miss_count", 64'(miss_count), 64'd1);
      wait_rel(320); check("s2_drain_addr", 64'(rom_addr), 64'd16);
                     check("s2_drain_busy", 64'(busy), 64'd1);
      wait_rel(539); check("s2_not_done", 64'(done), 64'd0);
      wait_rel(540); check("s2_done", 64'(done), 64'd1);
                     check("s2_idle_busy", 64'(busy), 64'd0);
      wait_rel(560); check("s2_done_held", 64'(done), 64'd1);
      go_idle();

      // four-lane miss crosses the limit
      load_song(4'b1111, 4'b0000);
      do_start();
      wait_rel(240); check("s3_miss4", 64'(miss_count), 64'd4);
                     check("s3_fail", 64'(fail), 64'd1);
                     check("s3_busy", 64'(busy), 64'd0);
      wait_rel(260); check("s3_fail_held", 64'(fail), 64'd1);
      do_start();    check("s3_restart_cnt", 64'(miss_count), 64'd0);
                     check("s3_restart_busy", 64'(busy), 64'd1);
      go_idle();

      // key edge judged in the same cycle as the shift
      load_song(4'b1000, 4'b0000);
      do_start();
      wait_rel(238); key = 4'b1000;
      wait_rel(240); check("s4_hit_at_shift", 64'(hit_pulse), 64'd1);
                     check("s4_no_miss", 64'(miss_count), 64'd0);
                     check("s4_no_miss_pulse", 64'(miss_pulse), 64'd0);
      go_idle();

      // held key across two consecutive notes
      load_song(4'b1000, 4'b1000);
      do_start();
      wait_rel(230); key = 4'b1000;
      wait_rel(232); check("s5_first_hit", 64'(hit_count), 64'd1);
      wait_rel(240); check("s5_second_note", 64'(grid[43:40]), 64'b1000);
      wait_rel(260); check("s5_held_no_hit", 64'(hit_count), 64'd1);
                     check("s5_held_miss", 64'(miss_count), 64'd1);
      go_idle();

      // all-zero song
      load_song(4'b0000, 4'b0000);
      do_start();
      wait_rel(540); check("s6_done", 64'(done), 64'd1);
                     check("s6_busy", 64'(busy), 64'd0);
      go_idle();

      // abort, ignored start, reset mid-song
      load_song(4'b1000, 4'b0000);
      do_start();
      wait_rel(100); check("s7_row4", 64'(grid[19:16]), 64'b1000);
                     abort = 1'b1;
      wait_rel(101); abort = 1'b0;
                     check("s7_abort_busy", 64'(busy), 64'd0);
                     check("s7_abort_grid", 64'(grid), 64'd0);
      do_start();
      wait_rel(50);  start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_rel(60);  check("s7_start_ignored", 64'(grid[11:8]), 64'b1000);
      wait_rel(70);  resetn = 1'b0;
      @(negedge clk);
      check("s7_reset_grid", 64'(grid), 64'd0);
      check("s7_reset_busy", 64'(busy), 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // randomized play
      for (int seg = 0; seg < 4; seg++) begin
         go_idle();
         for (int i = 0; i < SONG_LEN; i++)
            for (int b = 0; b < 4; b++) rom[i][b] = ($urandom_range(0, 3) == 0);
         do_start();
         for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++)
               if ($urandom_range(0, 5) == 0) key[b] = ~key[b];
            start  = ($urandom_range(0, 199) == 0);
            abort  = ($urandom_range(0, 999) == 0);
            resetn = ($urandom_range(0, 1499) != 0);
         end
         start  = 1'b0;
         abort  = 1'b0;
         resetn = 1'b1;
      end

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
